// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: locks one shared i2c master to a single client from START to STOP.
// Ties are settled round-robin or by fixed priority. Define I2C_ARB_TIMEOUT_EN for the watchdog.
module i2c_bus_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] c0_instruction,
  input  logic       c0_enable,
  input  logic [7:0] c0_byteToSend,
  output logic [7:0] c0_byteReceived,
  output logic       c0_complete,
  input  logic [1:0] c1_instruction,
  input  logic       c1_enable,
  input  logic [7:0] c1_byteToSend,
  output logic [7:0] c1_byteReceived,
  output logic       c1_complete,
  output logic [1:0] m_instruction,
  output logic       m_enable,
  output logic [7:0] m_byteToSend,
  input  logic [7:0] m_byteReceived,
  input  logic       m_complete,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout
);
  localparam int unsigned IW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 24;
  localparam logic [IW-1:0] INS_START = 2'd0;
  localparam logic [IW-1:0] INS_STOP  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [1:0]    grant_q, grant_n;
  logic          rr, rr_n;          // client index preferred on the next tie
  logic          stop_seen, stop_n;
  logic          wd_hit;
  logic          req0, req1;
  logic          own_en;
  logic [IW-1:0] own_ins;
  logic [DW-1:0] own_dat;

  assign req0    = c0_enable && (c0_instruction == INS_START);
  assign req1    = c1_enable && (c1_instruction == INS_START);
  assign own_en  = grant_q[1] ? c1_enable      : c0_enable;
  assign own_ins = grant_q[1] ? c1_instruction : c0_instruction;
  assign own_dat = grant_q[1] ? c1_byteToSend  : c0_byteToSend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant_q   <= 2'b00;
      rr        <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      rr        <= rr_n;
      stop_seen <= stop_n;
    end
  end

  always_comb begin
    state_n       = state;
    grant_n       = grant_q;
    rr_n          = rr;
    stop_n        = stop_seen;
    m_instruction = '0;
    m_enable      = 1'b0;
    m_byteToSend  = '0;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_n = ST_OWN;
          stop_n  = 1'b0;
          if (req0 && req1) grant_n = ((FIXED_PRIORITY != 0) || !rr) ? 2'b01 : 2'b10;
          else              grant_n = {req1, req0};
        end
      end
      ST_OWN: begin
        m_instruction = own_ins;
        m_enable      = own_en && !wd_hit;
        m_byteToSend  = own_dat;
        if ((own_ins == INS_STOP) && m_complete)    stop_n = 1'b1;
        else if (own_en && (own_ins == INS_START))  stop_n = 1'b0;
        if (wd_hit || (!own_en && stop_seen)) state_n = ST_RELEASE;
      end
      ST_RELEASE: begin
        // hand off only once the master has dropped complete for the STOP
        if (!m_complete || wd_hit) begin
          state_n = ST_IDLE;
          grant_n = 2'b00;
          rr_n    = grant_q[0];
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = 2'b00;
      end
    endcase
  end

  assign c0_complete     = grant_q[0] && m_complete;
  assign c1_complete     = grant_q[1] && m_complete;
  assign c0_byteReceived = grant_q[0] ? m_byteReceived : '0;
  assign c1_byteReceived = grant_q[1] ? m_byteReceived : '0;
  assign grant           = grant_q;
  assign busy            = (state != ST_IDLE);

`ifdef I2C_ARB_TIMEOUT_EN
  logic [CW-1:0] wd_cnt;
  logic          en_prev, cmp_prev, timeout_q;

  // watchdog restarts on any owner enable or master complete transition
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      en_prev   <= 1'b0;
      cmp_prev  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      en_prev  <= own_en;
      cmp_prev <= m_complete;
      if ((state == ST_IDLE) || (own_en != en_prev) || (m_complete != cmp_prev)) wd_cnt <= '0;
      else if (!wd_hit) wd_cnt <= wd_cnt + CW'(1);
      if (wd_hit) timeout_q <= 1'b1;
    end
  end

  assign wd_hit  = (state != ST_IDLE) && (wd_cnt >= TIMEOUT_CYCLES);
  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: round-robin and fixed-priority instances, randomized transactions
// against an arbitration model; watchdog checks follow I2C_ARB_TIMEOUT_EN.
module tb_i2c_bus_arbiter;
  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] STOP  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;
  localparam int unsigned TO_CYC = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // index [dut][client]; dut 0 round-robin, dut 1 fixed priority
  logic [1:0] ins [2][2];
  logic       en  [2][2];
  logic [7:0] tx  [2][2];
  logic [7:0] rx  [2][2];
  logic       cmp [2][2];
  logic [1:0] m_ins [2];
  logic       m_en  [2];
  logic [7:0] m_tx  [2];
  logic [7:0] m_rx  [2] = '{8'h00, 8'h00};
  logic       m_cmp [2] = '{1'b0, 1'b0};
  logic [1:0] gnt [2];
  logic       bsy [2];
  logic       tmo [2];
  logic       hang [2];

  int tests = 0;
  int fails = 0;
  int rr_model [2];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    i2c_bus_arbiter #(.FIXED_PRIORITY(d), .TIMEOUT_CYCLES(24'(TO_CYC))) u_dut (
      .clk(clk), .rst(rst),
      .c0_instruction(ins[d][0]), .c0_enable(en[d][0]), .c0_byteToSend(tx[d][0]),
      .c0_byteReceived(rx[d][0]), .c0_complete(cmp[d][0]),
      .c1_instruction(ins[d][1]), .c1_enable(en[d][1]), .c1_byteToSend(tx[d][1]),
      .c1_byteReceived(rx[d][1]), .c1_complete(cmp[d][1]),
      .m_instruction(m_ins[d]), .m_enable(m_en[d]), .m_byteToSend(m_tx[d]),
      .m_byteReceived(m_rx[d]), .m_complete(m_cmp[d]),
      .grant(gnt[d]), .busy(bsy[d]), .timeout(tmo[d])
    );
  end

  // i2c master model: completes one clk after enable, drops complete one clk after enable falls
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_en[d] === 1'b1 && !hang[d]) begin
        if (!m_cmp[d]) m_rx[d] <= 8'($urandom);
        m_cmp[d] <= 1'b1;
      end else begin
        m_cmp[d] <= 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hang[d] = 1'b0;
      for (int c = 0; c < 2; c++) en[d][c] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_model[0] = 0;
    rr_model[1] = 0;
    @(negedge clk);
  endtask

  // raise START for the requesting clients and check the arbitration outcome one clk later
  task automatic arbitrate(input int d, input bit r0, input bit r1, output int owner);
    int win;
    win = (r0 && r1) ? ((d == 1) ? 0 : rr_model[d]) : (r1 ? 1 : 0);
    if (r0) begin ins[d][0] = START; en[d][0] = 1'b1; end
    if (r1) begin ins[d][1] = START; en[d][1] = 1'b1; end
    @(negedge clk);
    tests++;
    if (gnt[d] !== 2'(1 << win)) begin
      fails++;
      $display("FAIL grant d%0d req=%b%b: got %b expected %b", d, r1, r0, gnt[d], 2'(1 << win));
    end
    tests++;
    if ({m_en[d], bsy[d]} !== 2'b11) begin
      fails++;
      $display("FAIL grant_latency d%0d: got m_enable=%b busy=%b expected 1 1", d, m_en[d], bsy[d]);
    end
    owner = win;
  endtask

  task automatic do_instr(input int d, input int c, input logic [1:0] op, input logic [7:0] dat);
    bit got, fwd_ok, iso_ok;
    int n;
    logic [10:0] seen;
    ins[d][c] = op; tx[d][c] = dat; en[d][c] = 1'b1;
    got = 1'b0; fwd_ok = 1'b1; iso_ok = 1'b1; seen = '0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if ({m_en[d], m_ins[d], m_tx[d]} !== {1'b1, op, dat}) begin
        fwd_ok = 1'b0;
        seen = {m_en[d], m_ins[d], m_tx[d]};
      end
      if (cmp[d][1-c] !== 1'b0) iso_ok = 1'b0;
      got = (cmp[d][c] === 1'b1);
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL complete d%0d c%0d op%0d: got 0 expected 1 within 20 clks", d, c, op);
    end
    tests++;
    if (!fwd_ok) begin
      fails++;
      $display("FAIL forward d%0d c%0d: got {en,ins,data}=%h expected %h", d, c, seen, {1'b1, op, dat});
    end
    tests++;
    if (!iso_ok) begin
      fails++;
      $display("FAIL isolate d%0d: non-owner c%0d complete got 1 expected 0", d, 1 - c);
    end
    if (got && op == READ) begin
      tests++;
      if (rx[d][c] !== m_rx[d]) begin
        fails++;
        $display("FAIL read_data d%0d c%0d: got %h expected %h", d, c, rx[d][c], m_rx[d]);
      end
    end
    en[d][c] = 1'b0;
    n = 0;
    while (cmp[d][c] !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (cmp[d][c] !== 1'b0) begin
      fails++;
      $display("FAIL complete_drop d%0d c%0d: got %b expected 0", d, c, cmp[d][c]);
    end
  endtask

  task automatic wait_release(input int d, input int c);
    int n;
    n = 0;
    while (gnt[d] !== 2'b00 && n < 12) begin @(negedge clk); n++; end
    tests++;
    if ({gnt[d], bsy[d]} !== 3'b000) begin
      fails++;
      $display("FAIL release d%0d: got grant=%b busy=%b expected 00 0", d, gnt[d], bsy[d]);
    end
    rr_model[d] = 1 - c;
  endtask

  task automatic serve(input int d, input int c, input int nops);
    logic [7:0] dat;
    do_instr(d, c, START, 8'h00);
    for (int i = 0; i < nops; i++) begin
      dat = 8'($urandom);
      if (en[d][1-c] === 1'b1 && dat == tx[d][1-c]) dat = ~dat;
      do_instr(d, c, ($urandom_range(0, 1) == 0) ? READ : WRITE, dat);
    end
    do_instr(d, c, STOP, 8'h00);
    wait_release(d, c);
  endtask

  task automatic run_txn(input int d, input bit r0, input bit r1, input int nops);
    int w, l;
    arbitrate(d, r0, r1, w);
    serve(d, w, nops);
    if (r0 && r1) begin
      l = 1 - w;
      @(negedge clk);
      tests++;
      if (gnt[d] !== 2'(1 << l)) begin
        fails++;
        $display("FAIL handoff d%0d: got %b expected %b", d, gnt[d], 2'(1 << l));
      end
      serve(d, l, nops);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        ins[d][c] = WRITE; tx[d][c] = 8'($urandom) | 8'h01; en[d][c] = 1'b0;
      end
      hang[d] = 1'b0;
      rr_model[d] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({gnt[d], bsy[d], m_en[d], m_ins[d], m_tx[d]} !== 14'h0) begin
        fails++;
        $display("FAIL reset_bus d%0d: got grant=%b busy=%b m_en=%b ins=%0d data=%h expected all 0",
                 d, gnt[d], bsy[d], m_en[d], m_ins[d], m_tx[d]);
      end
      tests++;
      if ({cmp[d][0], cmp[d][1], rx[d][0], rx[d][1], tmo[d]} !== 19'h0) begin
        fails++;
        $display("FAIL reset_clients d%0d: got cmp=%b%b rx=%h/%h timeout=%b expected all 0",
                 d, cmp[d][1], cmp[d][0], rx[d][1], rx[d][0], tmo[d]);
      end
    end
  endtask

  task automatic test_single();
    int w;
    arbitrate(0, 1'b1, 1'b0, w);
    do_instr(0, 0, START, 8'h00);
    do_instr(0, 0, WRITE, 8'h92);
    do_instr(0, 0, STOP, 8'h00);
    wait_release(0, 0);
  endtask

  task automatic test_tie();
    do_reset();
    run_txn(0, 1'b1, 1'b1, 1);
    run_txn(0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < 4; i++) run_txn(1, 1'b1, 1'b1, $urandom_range(0, 2));
    run_txn(1, 1'b0, 1'b1, 0);
    run_txn(1, 1'b1, 1'b1, 1);
  endtask

  task automatic test_non_owner();
    int w;
    bool_loop: begin end
    arbitrate(0, 1'b1, 1'b0, w);
    ins[0][1] = WRITE; tx[0][1] = 8'h5A; en[0][1] = 1'b1;
    serve(0, w, 3);
    begin
      bit idle_ok;
      idle_ok = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if ({gnt[0], m_en[0], cmp[0][1]} !== 4'b0000) idle_ok = 1'b0;
      end
      tests++;
      if (!idle_ok) begin
        fails++;
        $display("FAIL non_owner_ignored: got grant=%b m_en=%b c1_complete=%b expected 00 0 0",
                 gnt[0], m_en[0], cmp[0][1]);
      end
    end
    en[0][1] = 1'b0;
  endtask

  task automatic test_random();
    bit r0, r1;
    int d;
    for (int i = 0; i < 20; i++) begin
      d  = $urandom_range(0, 1);
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(d, r0, r1, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    int w;
    arbitrate(0, 1'b1, 1'b0, w);
    do_instr(0, 0, START, 8'h00);
    ins[0][0] = READ; tx[0][0] = 8'h00; en[0][0] = 1'b1;
    @(negedge clk);
    tests++;
    if ({m_en[0], cmp[0][0]} !== 2'b11) begin
      fails++;
      $display("FAIL mid_read d0: got m_en=%b complete=%b expected 1 1", m_en[0], cmp[0][0]);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({m_en[0], gnt[0], bsy[0]} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_bus: got m_en=%b grant=%b busy=%b expected 0 00 0", m_en[0], gnt[0], bsy[0]);
    end
    tests++;
    if ({cmp[0][0], cmp[0][1], rx[0][0]} !== 10'h0) begin
      fails++;
      $display("FAIL reset_mid_client: got cmp=%b%b rx=%h expected 0 0 00", cmp[0][1], cmp[0][0], rx[0][0]);
    end
    rst = 1'b0;
    en[0][0] = 1'b0;
    rr_model[0] = 0;
    rr_model[1] = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int w;
    arbitrate(0, 1'b1, 1'b0, w);
    do_instr(0, 0, START, 8'h00);
    hang[0] = 1'b1;
    ins[0][0] = READ; en[0][0] = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (m_en[0] === 1'b1 && n < 300);
      tests++;
      if (n - 1 < int'(TO_CYC) - 1 || n - 1 > int'(TO_CYC) + 1) begin
        fails++;
        $display("FAIL watchdog_cycles: got m_enable high %0d clks expected %0d", n - 1, TO_CYC);
      end
      repeat (2) @(negedge clk);
      tests++;
      if ({tmo[0], gnt[0], m_en[0]} !== 4'b1000) begin
        fails++;
        $display("FAIL watchdog_release: got timeout=%b grant=%b m_en=%b expected 1 00 0", tmo[0], gnt[0], m_en[0]);
      end
      en[0][0] = 1'b0;
      hang[0] = 1'b0;
      rr_model[0] = 1;
      run_txn(0, 1'b0, 1'b1, 1);
      tests++;
      if (tmo[0] !== 1'b1) begin
        fails++;
        $display("FAIL timeout_sticky: got %b expected 1", tmo[0]);
      end
      do_reset();
      tests++;
      if (tmo[0] !== 1'b0) begin
        fails++;
        $display("FAIL timeout_rst: got %b expected 0", tmo[0]);
      end
    end
`else
    repeat (150) @(negedge clk);
    tests++;
    if ({m_en[0], gnt[0], tmo[0]} !== 4'b1010) begin
      fails++;
      $display("FAIL hung_owner: got m_en=%b grant=%b timeout=%b expected 1 01 0", m_en[0], gnt[0], tmo[0]);
    end
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fixed_priority();
    test_non_owner();
    test_random();
    test_reset_mid();
    test_timeout();
    run_txn(0, 1'b1, 1'b1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
